fir_out_buffer: RTL and testbench
=================================

# fir_out_buffer

Output-side elastic buffer placed directly downstream of the FIR filter. It captures every valid 9-bit filter sample (`DIN` qualified by `VIN`, which the filter drives with no backpressure) into a small first-word-fall-through FIFO. It presents the samples to the next consumer (data sink or later stage) through a valid/ready handshake. Samples arriving while the buffer is full are dropped and flagged.

## Interface
- `WIDTH`, 9: sample width; matches the FIR output width.
- `DEPTH`, 8: number of entries; power of two, ≥ 2.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_n`  in  1  asynchronous active-low reset.
- `DIN`  in  WIDTH  sample from the FIR `DOUT`.
- `VIN`  in  1  sample valid, from the FIR `VOUT`; one strobe = one sample.
- `DOUT`  out  WIDTH  head-of-FIFO sample.
- `VOUT`  out  1  `DOUT` is valid.
- `RDY`  in  1  consumer accepts `DOUT` this cycle.
- `FULL`  out  1  all `DEPTH` entries occupied.
- `EMPTY`  out  1  no entries occupied.
- `OVF`  out  1  sticky: at least one sample dropped since reset.

## Operation
- **Storage:** `DEPTH` x `WIDTH` register array.
  - Write pointer and read pointer are each log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - Occupancy counter is log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- **Pop:** occurs when `VOUT` and `RDY` are both high in a cycle. The read pointer advances.
- **Push:** occurs when `VIN` is high and either:
  - the FIFO is not full, or
  - the FIFO is full and a pop occurs in the same cycle.
  
  On a push, `DIN` is stored at the write pointer and the write pointer advances.
- **Drop:** `VIN` high, FIFO full and no pop in the same cycle. The sample is discarded, no state changes except `OVF`, and the pointers are untouched.
- **Occupancy:** +1 on push only, −1 on pop only, unchanged on push and pop together.
- **Empty buffer:** `VIN` and `RDY` high together perform a push only. There is no bypass: `VOUT` is low that cycle, so no pop can occur.
- **Status outputs:**
  - `VOUT` = `!EMPTY`.
  - `DOUT` = entry at the read pointer (FWFT). `DOUT` is don't-care while `VOUT` = 0.
  - `EMPTY` = (count == 0); `FULL` = (count == `DEPTH`). Both are decoded from the registered count.
- **`OVF`:** set on the clock edge that performs a drop and held until reset.
- **Data path:** no arithmetic. Samples pass bit-exact, two's complement preserved.
- **State:** no FSM beyond the pointers and counter.

## Timing
- **Reset:** while `RST_n` = 0, pointers = 0, count = 0, `EMPTY` = 1, `FULL` = 0, `VOUT` = 0, `OVF` = 0.
  - `DOUT` resets to 0. Array contents are not reset.
  - Reset mid-operation discards all stored samples immediately (asynchronously).
  - The first push is possible on the first rising edge after `RST_n` rises.
- **Latency:** a sample pushed at edge k appears on `DOUT` with `VOUT` = 1 after edge k, i.e. in cycle k+1, when the FIFO was empty.
- **Throughput:** one push and one pop per cycle sustained.
- **Handshake:** the consumer may drop `RDY` at any time. `DOUT`/`VOUT` hold stable until a pop or reset.
- **Status update:** `FULL`/`EMPTY` reflect the state after the edge, so they change one cycle after the causing push or pop.
- **Wrap-around:** pointers wrap from `DEPTH`−1 to 0 with no bubble.

## Configuration
- **`FIR_BUF_DROPCNT_EN`**
  - **Defined:** adds output `DROP_CNT` (out, 8 bits).
    - Increments by 1 on every drop and saturates at 255.
    - Resets to 0 asynchronously.
    - `OVF` = (`DROP_CNT` != 0) equivalently.
  - **Undefined:** the port and counter are absent; only the sticky `OVF` is provided.

## Test plan
- **Basic fill and drain:**
  - Stimulus: after reset, push 0x001, 0x1FF, 0x100 on consecutive cycles with `RDY` = 0, then hold `RDY` = 1.
  - Response: `VOUT` rises in the cycle after the first push; `DOUT` reads 0x001, 0x1FF, 0x100 on successive cycles; then `EMPTY` = 1.
- **Overflow:**
  - Stimulus: `RDY` = 0, push 9 samples 0x000..0x008.
  - Response: `FULL` = 1 after the 8th push; the 9th sample is dropped and `OVF` = 1 from the next cycle. Draining yields 0x000..0x007 only. With `FIR_BUF_DROPCNT_EN` defined, `DROP_CNT` = 1.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full with 0x000..0x007; `VIN` = 1 with `DIN` = 0x0AA and `RDY` = 1 in the same cycle.
  - Response: 0x000 popped, 0x0AA accepted, `FULL` stays 1, `OVF` stays 0. The drain order ends with 0x0AA.
- **Sustained streaming:**
  - Stimulus: `VIN` = 1 and `RDY` = 1 continuously for 20 cycles with an incrementing pattern.
  - Response: output equals input delayed by one cycle; count stays ≤ 1; pointers wrap with no loss.
- **Reset mid-operation:**
  - Stimulus: with 5 entries stored, assert `RST_n` = 0 between edges.
  - Response: `VOUT`, `FULL`, `OVF` and `DOUT` go to 0 and `EMPTY` goes to 1 immediately; no old samples appear after reset is released.
- **Drop-counter saturation** (`FIR_BUF_DROPCNT_EN` defined):
  - Stimulus: hold the FIFO full and drive 300 `VIN` strobes.
  - Response: `DROP_CNT` = 255 and stays there.

Source files
------------

// File: rtl/fir_out_buffer_if.sv
// fir_out_buffer_if
// Bundles the sample input strobe, the valid/ready output handshake and the
// buffer status flags between the FIR output buffer and its neighbours.
// Optional feature macro: FIR_BUF_DROPCNT_EN (adds the DROP_CNT signal).
//
// Handshake semantics (output side): a sample transfers on every rising
// clock edge where VOUT and RDY are both high. VOUT/DOUT hold stable until
// that transfer happens (or reset). RDY may change freely at any time.
// The input side has no backpressure: each VIN strobe is one sample, and it
// is either stored or dropped.
interface fir_out_buffer_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] DIN;
  logic             VIN;
  logic [WIDTH-1:0] DOUT;
  logic             VOUT;
  logic             RDY;
  logic             FULL;
  logic             EMPTY;
  logic             OVF;
`ifdef FIR_BUF_DROPCNT_EN
  logic [7:0]       DROP_CNT;
`endif

  // Buffer side: receives samples and ready, drives data/valid/status
  modport slave (
    input  DIN,
    input  VIN,
    input  RDY,
    output DOUT,
    output VOUT,
    output FULL,
    output EMPTY,
    output OVF
`ifdef FIR_BUF_DROPCNT_EN
    ,
    output DROP_CNT
`endif
  );

  // Environment side: drives samples and ready, observes data/valid/status
  modport master (
    output DIN,
    output VIN,
    output RDY,
    input  DOUT,
    input  VOUT,
    input  FULL,
    input  EMPTY,
    input  OVF
`ifdef FIR_BUF_DROPCNT_EN
    ,
    input  DROP_CNT
`endif
  );
endinterface

// File: rtl/fir_out_buffer.sv
// fir_out_buffer
// First-word-fall-through elastic buffer behind the FIR filter. Every valid
// filter sample is captured into a DEPTH x WIDTH register array; the head
// entry is offered to the consumer with a valid/ready handshake. Samples that
// arrive while the buffer is full (and no pop frees a slot that same cycle)
// are discarded and recorded in the sticky OVF flag.
// Optional feature macro: FIR_BUF_DROPCNT_EN adds an 8-bit saturating drop
// counter (DROP_CNT); OVF is then derived from it.
// No FSM: the only state is the array, two pointers, the occupancy counter
// and the overflow tracking.
module fir_out_buffer #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic               CLK,
  input  logic               RST_n,
  fir_out_buffer_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  // Sized constants so pointer/count arithmetic stays width-exact
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);
  localparam logic [AW:0]   L_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   L_DEPTH   = (AW + 1)'(DEPTH);

  // Storage and bookkeeping
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Decoded status and per-cycle events
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status comes straight from the registered count, so FULL/EMPTY reflect
  // the state after the edge that caused them.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_DEPTH);

  // A pop needs a valid head entry; there is no bypass, so an empty buffer
  // never pops even when a sample arrives in the same cycle.
  assign w_pop  = !w_empty && bus.RDY;

  // A full buffer can still accept a sample if a pop frees the head slot in
  // the same cycle; in that case the write lands in the slot being vacated.
  assign w_push = bus.VIN && (!w_full || w_pop);
  assign w_drop = bus.VIN && w_full && !w_pop;

  // Sample array write; contents are intentionally left unreset
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.DIN;
    end
  end

  // Write pointer: advances on every accepted sample, wraps modulo DEPTH
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
    end
  end

  // Read pointer: advances on every completed handshake, wraps modulo DEPTH
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
    end
  end

  // Occupancy: +1 push only, -1 pop only, hold when both or neither
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIR_BUF_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of discarded samples; nonzero means overflow occurred
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.DROP_CNT = r_drop_cnt;
  assign bus.OVF      = (r_drop_cnt != 8'd0);
`else
  logic r_ovf;

  // Sticky overflow flag: set on the first drop, cleared only by reset
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.OVF = r_ovf;
`endif

  // Outputs. DOUT is forced to zero while empty so that it reads 0 during
  // and right after reset even though the array itself is not cleared.
  assign bus.DOUT  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.VOUT  = !w_empty;
  assign bus.FULL  = w_full;
  assign bus.EMPTY = w_empty;

endmodule

// File: tb/tb_fir_out_buffer.sv
// tb_fir_out_buffer
// Directed bench for fir_out_buffer: reset state, fill/drain, overflow drop,
// full buffer with simultaneous push and pop, asynchronous reset in the
// middle of operation, sustained streaming with pointer wrap, and (with
// FIR_BUF_DROPCNT_EN) drop-counter saturation.
module tb_fir_out_buffer;

  localparam int WIDTH = 9;
  localparam int DEPTH = 8;

  logic CLK;
  logic RST_n;

  int tests_run;
  int tests_failed;

  fir_out_buffer_if #(.WIDTH(WIDTH)) bus ();

  fir_out_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  // Clock: 10 time-unit period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle so outputs show the post-edge state
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] exp_drain [DEPTH];
  logic [WIDTH-1:0] stream_val;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST_n  = 1'b0;
    bus.VIN = 1'b0;
    bus.DIN = '0;
    bus.RDY = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full",  32'(bus.FULL),  32'd0);
    check("rst_vout",  32'(bus.VOUT),  32'd0);
    check("rst_ovf",   32'(bus.OVF),   32'd0);
    check("rst_dout",  32'(bus.DOUT),  32'd0);
`ifdef FIR_BUF_DROPCNT_EN
    check("rst_dropcnt", 32'(bus.DROP_CNT), 32'd0);
`endif
    RST_n = 1'b1;

    // ---------------- basic fill and drain ----------------
    bus.VIN = 1'b1;
    bus.DIN = 9'h001;
    step();
    check("fill_vout_first", 32'(bus.VOUT), 32'd1);
    check("fill_dout_first", 32'(bus.DOUT), 32'h001);
    bus.DIN = 9'h1FF;
    step();
    bus.DIN = 9'h100;
    step();
    bus.VIN = 1'b0;
    check("fill_head_held", 32'(bus.DOUT), 32'h001);
    check("fill_not_empty", 32'(bus.EMPTY), 32'd0);
    bus.RDY = 1'b1;
    step();
    check("drain_1ff", 32'(bus.DOUT), 32'h1FF);
    step();
    check("drain_100", 32'(bus.DOUT), 32'h100);
    check("drain_vout", 32'(bus.VOUT), 32'd1);
    step();
    check("drain_empty", 32'(bus.EMPTY), 32'd1);
    check("drain_vout_low", 32'(bus.VOUT), 32'd0);
    bus.RDY = 1'b0;

    // ---------------- overflow ----------------
    for (int i = 0; i < DEPTH; i++) begin
      bus.VIN = 1'b1;
      bus.DIN = WIDTH'(i);
      step();
    end
    check("ovf_full_after_8", 32'(bus.FULL), 32'd1);
    check("ovf_not_yet", 32'(bus.OVF), 32'd0);
    bus.DIN = 9'h008;
    step();
    bus.VIN = 1'b0;
    check("ovf_set", 32'(bus.OVF), 32'd1);
    check("ovf_still_full", 32'(bus.FULL), 32'd1);
`ifdef FIR_BUF_DROPCNT_EN
    check("ovf_dropcnt", 32'(bus.DROP_CNT), 32'd1);
`endif
    bus.RDY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_drain_%0d", i), 32'(bus.DOUT), 32'(i));
      step();
    end
    check("ovf_drained_empty", 32'(bus.EMPTY), 32'd1);
    check("ovf_sticky", 32'(bus.OVF), 32'd1);
    bus.RDY = 1'b0;

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      bus.VIN = 1'b1;
      bus.DIN = WIDTH'(9'h150 + i);
      step();
    end
    bus.VIN = 1'b0;
    check("mid_five_stored", 32'(bus.DOUT), 32'h150);
    #2;
    RST_n = 1'b0;
    #1;
    check("mid_rst_vout",  32'(bus.VOUT),  32'd0);
    check("mid_rst_full",  32'(bus.FULL),  32'd0);
    check("mid_rst_ovf",   32'(bus.OVF),   32'd0);
    check("mid_rst_dout",  32'(bus.DOUT),  32'd0);
    check("mid_rst_empty", 32'(bus.EMPTY), 32'd1);
    step();
    #2;
    RST_n = 1'b1;
    bus.RDY = 1'b1;
    step();
    step();
    check("mid_post_empty", 32'(bus.EMPTY), 32'd1);
    check("mid_post_vout", 32'(bus.VOUT), 32'd0);
    bus.RDY = 1'b0;

    // ---------------- full with simultaneous push and pop ----------------
    for (int i = 0; i < DEPTH; i++) begin
      bus.VIN = 1'b1;
      bus.DIN = WIDTH'(i);
      step();
    end
    check("pp_full", 32'(bus.FULL), 32'd1);
    bus.DIN = 9'h0AA;
    bus.RDY = 1'b1;
    step();
    bus.VIN = 1'b0;
    check("pp_still_full", 32'(bus.FULL), 32'd1);
    check("pp_no_ovf", 32'(bus.OVF), 32'd0);
    check("pp_head_001", 32'(bus.DOUT), 32'h001);
    for (int i = 0; i < DEPTH - 1; i++) exp_drain[i] = WIDTH'(i + 1);
    exp_drain[DEPTH-1] = 9'h0AA;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(bus.DOUT), 32'(exp_drain[i]));
      step();
    end
    check("pp_drained_empty", 32'(bus.EMPTY), 32'd1);
    check("pp_ovf_clear", 32'(bus.OVF), 32'd0);

    // ---------------- holding RDY low keeps head stable ----------------
    bus.RDY = 1'b0;
    bus.VIN = 1'b1;
    bus.DIN = 9'h0C3;
    step();
    bus.VIN = 1'b0;
    step();
    step();
    check("hold_dout", 32'(bus.DOUT), 32'h0C3);
    check("hold_vout", 32'(bus.VOUT), 32'd1);
    bus.RDY = 1'b1;
    step();
    check("hold_popped", 32'(bus.EMPTY), 32'd1);

    // ---------------- sustained streaming ----------------
    bus.VIN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stream_val = WIDTH'(9'h0F0 + 9'(i * 7));
      bus.DIN = stream_val;
      step();
      check($sformatf("stream_dout_%0d", i), 32'(bus.DOUT), 32'(stream_val));
      check($sformatf("stream_vout_%0d", i), 32'(bus.VOUT), 32'd1);
      check($sformatf("stream_notfull_%0d", i), 32'(bus.FULL), 32'd0);
    end
    bus.VIN = 1'b0;
    step();
    check("stream_end_empty", 32'(bus.EMPTY), 32'd1);
    check("stream_no_ovf", 32'(bus.OVF), 32'd0);
    bus.RDY = 1'b0;

`ifdef FIR_BUF_DROPCNT_EN
    // ---------------- drop-counter saturation ----------------
    for (int i = 0; i < DEPTH; i++) begin
      bus.VIN = 1'b1;
      bus.DIN = WIDTH'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      bus.DIN = 9'h055;
      step();
    end
    check("sat_dropcnt", 32'(bus.DROP_CNT), 32'd255);
    for (int i = 0; i < 10; i++) step();
    bus.VIN = 1'b0;
    check("sat_dropcnt_held", 32'(bus.DROP_CNT), 32'd255);
    check("sat_ovf", 32'(bus.OVF), 32'd1);
    check("sat_head", 32'(bus.DOUT), 32'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
